// File: rtl/glyph_row_fetch_if.sv
// Bundle of the glyph row fetcher's request, font ROM and pixel stream signals.
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high. Once a source raises valid it keeps valid and its payload
// stable until that transfer. The sink may move ready freely, and ready may
// depend on valid.
interface glyph_row_fetch_if #(
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_glyph;
  logic [4:0]        req_row;
  logic              rom_rd;
  logic [12:0]       rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] pix_data;
  logic              pix_last;
  logic              busy;
  logic [1:0]        dbg_state;

  // View seen by the fetcher itself.
  modport slave (
    input  req_valid, req_glyph, req_row, rom_data, pix_ready,
    output req_ready, rom_rd, rom_addr, pix_valid, pix_data, pix_last,
           busy, dbg_state
  );

  // View seen by the surrounding logic: glyph select, ROM and serializer.
  modport master (
    output req_valid, req_glyph, req_row, rom_data, pix_ready,
    input  req_ready, rom_rd, rom_addr, pix_valid, pix_data, pix_last,
           busy, dbg_state
  );
endinterface

// File: rtl/glyph_row_fetch.sv
// Fetches one 16-word glyph row from the font ROM into a local buffer, then
// streams the buffered row to the pixel serializer.
module glyph_row_fetch #(
  parameter int ROM_LATENCY = 2,
  parameter int DATA_W      = 8
) (
  input  logic               clk_50MHz,
  input  logic               reset_n,
  glyph_row_fetch_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Glyph and row are latched into the upper address bits at acceptance; only
  // the low nibble (the column) advances during a fetch.
  logic              r_rom_rd;
  logic [12:0]       r_rom_addr;

  // Tag pipeline follows each strobe through the ROM latency.
  logic [ROM_LATENCY-1:0] r_tag_vld;
  logic [3:0]             r_tag_col [ROM_LATENCY];

  logic [DATA_W-1:0] r_buf [16];

  logic              r_pix_valid;
  logic [DATA_W-1:0] r_pix_data;
  logic              r_pix_last;
  logic [3:0]        r_pix_idx;

  logic              w_accept;
  logic              w_cap;
  logic [3:0]        w_cap_col;
  logic              w_cap_last;
  logic [3:0]        w_idx_nxt;

  assign w_cap      = r_tag_vld[ROM_LATENCY-1];
  assign w_cap_col  = r_tag_col[ROM_LATENCY-1];
  assign w_cap_last = w_cap && (w_cap_col == 4'hF);
  assign w_idx_nxt  = r_pix_idx + 4'd1;

  // State register.
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and request acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (r_rom_addr[3:0] == 4'hF) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_cap_last) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.pix_ready && (r_pix_idx == 4'hF)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ROM strobe/address generation and the pixel output register.
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_rom_rd    <= 1'b0;
      r_rom_addr  <= '0;
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
      r_pix_last  <= 1'b0;
      r_pix_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rom_rd   <= 1'b1;
            r_rom_addr <= {bus.req_glyph, bus.req_row, 4'h0};
          end
        end
        S_FETCH: begin
          if (r_rom_addr[3:0] == 4'hF) begin
            r_rom_rd <= 1'b0;
          end else begin
            r_rom_addr[3:0] <= r_rom_addr[3:0] + 4'd1;
          end
        end
        S_WAIT: begin
          // Word 0 was captured long ago; present it as the last word lands.
          if (w_cap_last) begin
            r_pix_valid <= 1'b1;
            r_pix_data  <= r_buf[0];
            r_pix_last  <= 1'b0;
            r_pix_idx   <= 4'd0;
          end
        end
        S_DRAIN: begin
          if (bus.pix_ready) begin
            if (r_pix_idx == 4'hF) begin
              r_pix_valid <= 1'b0;
              r_pix_data  <= '0;
              r_pix_last  <= 1'b0;
            end else begin
              r_pix_idx  <= w_idx_nxt;
              r_pix_data <= r_buf[w_idx_nxt];
              r_pix_last <= (w_idx_nxt == 4'hF);
            end
          end
        end
        default: begin
          r_rom_rd    <= 1'b0;
          r_pix_valid <= 1'b0;
        end
      endcase
    end
  end

  // Shift (strobe, col) tags so each returning ROM word knows its column.
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROM_LATENCY; i++) begin
        r_tag_vld[i] <= 1'b0;
        r_tag_col[i] <= 4'h0;
      end
    end else begin
      r_tag_vld[0] <= r_rom_rd;
      r_tag_col[0] <= r_rom_addr[3:0];
      for (int i = 1; i < ROM_LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_col[i] <= r_tag_col[i-1];
      end
    end
  end

  // Row buffer write; contents are irrelevant after reset, so no reset here.
  always_ff @(posedge clk_50MHz) begin
    if (w_cap) begin
      r_buf[w_cap_col] <= bus.rom_data;
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.dbg_state = r_state;
  assign bus.rom_rd    = r_rom_rd;
  assign bus.rom_addr  = r_rom_addr;
  assign bus.pix_valid = r_pix_valid;
  assign bus.pix_data  = r_pix_data;
  assign bus.pix_last  = r_pix_last;

endmodule

// File: tb/tb_glyph_row_fetch.sv
// Bench for glyph_row_fetch: a main instance at ROM latency 2 plus instances at
// latency 1 and 4 for the latency sweep.
module tb_glyph_row_fetch;

  localparam int L0 = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs and ROM models ----------------
  glyph_row_fetch_if #(.DATA_W(8)) if0 ();
  glyph_row_fetch_if #(.DATA_W(8)) if1 ();
  glyph_row_fetch_if #(.DATA_W(8)) if4 ();

  glyph_row_fetch #(.ROM_LATENCY(L0), .DATA_W(8)) u_dut0 (
    .clk_50MHz (clk), .reset_n (reset_n), .bus (if0));
  glyph_row_fetch #(.ROM_LATENCY(1), .DATA_W(8)) u_dut1 (
    .clk_50MHz (clk), .reset_n (reset_n), .bus (if1));
  glyph_row_fetch #(.ROM_LATENCY(4), .DATA_W(8)) u_dut4 (
    .clk_50MHz (clk), .reset_n (reset_n), .bus (if4));

  // ROM returns addr[7:0] L cycles after the registered strobe.
  logic [12:0] rom_p0 [L0];
  logic [12:0] rom_p1 [1];
  logic [12:0] rom_p4 [4];

  always @(posedge clk) begin
    rom_p0[0] <= if0.rom_addr;
    rom_p0[1] <= rom_p0[0];
    rom_p1[0] <= if1.rom_addr;
    rom_p4[0] <= if4.rom_addr;
    for (int i = 1; i < 4; i++) rom_p4[i] <= rom_p4[i-1];
  end

  assign if0.rom_data = rom_p0[L0-1][7:0];
  assign if1.rom_data = rom_p1[0][7:0];
  assign if4.rom_data = rom_p4[3][7:0];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------- scoreboard state ----------------
  logic [8:0]  exp_q  [$];   // {last, data} per expected pixel word
  logic [12:0] addr_q [$];   // expected ROM addresses
  int          t_q    [$];   // acceptance edge per expected row

  int   beat = 0, stalls = 0, n_valid_seen = 0, bp_left = 0;
  bit   in_row = 0, held = 0, idle_chk = 0, bp_mode = 0, bp_done = 0;
  logic [7:0] prev_data;
  logic       prev_last;

  // ---------------- driver tasks ----------------
  // Present a request; record the acceptance edge and push the expected row.
  task automatic send_req(input logic [3:0] g, input logic [4:0] r,
                          input bit keep_valid, output int t_acc);
    int n;
    logic [31:0] a;
    if0.req_glyph = g;
    if0.req_row   = r;
    if0.req_valid = 1'b1;
    n = 0;
    while (!if0.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("req_timeout", {31'd0, if0.req_ready}, 32'd1);
    t_acc = cyc + 1;
    for (int c = 0; c < 16; c++) begin
      a = g * 512 + r * 16 + c;
      addr_q.push_back(a[12:0]);
      exp_q.push_back({(c == 15), a[7:0]});
    end
    t_q.push_back(t_acc);
    @(negedge clk);
    if (!keep_valid) if0.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || addr_q.size() != 0 || !if0.req_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  // ---------------- monitor for the main instance ----------------
  always @(negedge clk) begin
    #1;
    if (!reset_n) begin
      beat = 0; stalls = 0; in_row = 0; held = 0; idle_chk = 0;
      bp_left = 0; bp_done = 0;
      if0.pix_ready = 1'b1;
    end else begin
      if (idle_chk) begin
        chk("idle_req_ready", {31'd0, if0.req_ready}, 32'd1);
        chk("idle_busy", {31'd0, if0.busy}, 32'd0);
        idle_chk = 0;
      end
      if (if0.rom_rd) begin
        if (addr_q.size() == 0) chk("rom_rd_unexpected", {31'd0, if0.rom_rd}, 32'd0);
        else chk("rom_addr", {19'd0, if0.rom_addr}, {19'd0, addr_q.pop_front()});
      end
      if (if0.pix_valid) begin
        n_valid_seen++;
        if (bp_left > 0) begin
          bp_left--;
          if (bp_left == 0) if0.pix_ready = 1'b1;
        end else if (bp_mode && !bp_done && beat == 7) begin
          if0.pix_ready = 1'b0;
          bp_left = 3;
          bp_done = 1;
        end
        if (held) begin
          chk("hold_data", {24'd0, if0.pix_data}, {24'd0, prev_data});
          chk("hold_last", {31'd0, if0.pix_last}, {31'd0, prev_last});
        end
        if (!in_row) begin
          in_row = 1;
          if (t_q.size() == 0) chk("pix_unexpected", {31'd0, if0.pix_valid}, 32'd0);
          else chk("first_valid_cycle", cyc, t_q[0] + 16 + L0);
        end
        if (if0.pix_ready) begin
          if (exp_q.size() == 0) chk("pix_extra", {31'd0, if0.pix_valid}, 32'd0);
          else chk("pix_word", {23'd0, if0.pix_last, if0.pix_data}, {23'd0, exp_q.pop_front()});
          held = 0;
          beat++;
          if (beat == 16) begin
            if (t_q.size() != 0) chk("row_end_cycle", cyc, t_q.pop_front() + 31 + L0 + stalls);
            beat = 0; stalls = 0; in_row = 0; bp_done = 0; idle_chk = 1;
          end
        end else begin
          held = 1;
          prev_data = if0.pix_data;
          prev_last = if0.pix_last;
          stalls++;
        end
      end else begin
        if (in_row) chk("valid_gap", {31'd0, if0.pix_valid}, 32'd1);
        held = 0;
      end
    end
  end

  // ---------------- latency sweep (L=1 and L=4 side by side) ----------------
  task automatic lat_sweep();
    logic [8:0]  q1 [$];
    logic [8:0]  q4 [$];
    logic [31:0] a;
    int t;
    bit seen1, seen4;
    seen1 = 0;
    seen4 = 0;
    chk("lat_req_ready", {30'd0, if1.req_ready, if4.req_ready}, 32'd3);
    if1.req_glyph = 4'h3; if1.req_row = 5'd5; if1.req_valid = 1'b1;
    if4.req_glyph = 4'h3; if4.req_row = 5'd5; if4.req_valid = 1'b1;
    t = cyc + 1;
    for (int c = 0; c < 16; c++) begin
      a = 3 * 512 + 5 * 16 + c;
      q1.push_back({(c == 15), a[7:0]});
      q4.push_back({(c == 15), a[7:0]});
    end
    @(negedge clk);
    if1.req_valid = 1'b0;
    if4.req_valid = 1'b0;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (if1.pix_valid) begin
        if (!seen1) begin chk("lat1_first_valid", cyc, t + 17); seen1 = 1; end
        if (q1.size() == 0) chk("lat1_extra", {31'd0, if1.pix_valid}, 32'd0);
        else chk("lat1_word", {23'd0, if1.pix_last, if1.pix_data}, {23'd0, q1.pop_front()});
      end
      if (if4.pix_valid) begin
        if (!seen4) begin chk("lat4_first_valid", cyc, t + 20); seen4 = 1; end
        if (q4.size() == 0) chk("lat4_extra", {31'd0, if4.pix_valid}, 32'd0);
        else chk("lat4_word", {23'd0, if4.pix_last, if4.pix_data}, {23'd0, q4.pop_front()});
      end
      @(negedge clk);
    end
    chk("lat1_count", q1.size(), 0);
    chk("lat4_count", q4.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t, t1, t2, seen;
    if0.req_valid = 1'b0; if0.req_glyph = '0; if0.req_row = '0; if0.pix_ready = 1'b1;
    if1.req_valid = 1'b0; if1.req_glyph = '0; if1.req_row = '0; if1.pix_ready = 1'b1;
    if4.req_valid = 1'b0; if4.req_glyph = '0; if4.req_row = '0; if4.pix_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", {31'd0, if0.req_ready}, 32'd1);
    chk("rst_rom_rd",    {31'd0, if0.rom_rd},    32'd0);
    chk("rst_rom_addr",  {19'd0, if0.rom_addr},  32'd0);
    chk("rst_pix_valid", {31'd0, if0.pix_valid}, 32'd0);
    chk("rst_pix_data",  {24'd0, if0.pix_data},  32'd0);
    chk("rst_pix_last",  {31'd0, if0.pix_last},  32'd0);
    chk("rst_busy",      {31'd0, if0.busy},      32'd0);
    chk("rst_state",     {30'd0, if0.dbg_state}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic fetch, then address boundaries
    send_req(4'h3, 5'd5, 1'b0, t);
    #1 chk("busy_after_accept", {31'd0, if0.busy}, 32'd1);
    wait_idle();
    send_req(4'hF, 5'd31, 1'b0, t);
    wait_idle();
    send_req(4'h0, 5'd0, 1'b0, t);
    wait_idle();

    // Back-pressure on word 7
    bp_mode = 1;
    send_req(4'hA, 5'd9, 1'b0, t);
    wait_idle();
    bp_mode = 0;

    // Busy rejection: request held high with new codes through the fetch
    send_req(4'h6, 5'd12, 1'b1, t1);
    if0.req_glyph = 4'h9;
    if0.req_row   = 5'd3;
    send_req(4'h9, 5'd3, 1'b0, t2);
    chk("reaccept_edge", t2, t1 + 33 + L0);
    wait_idle();

    // Reset mid-FETCH
    send_req(4'h1, 5'd2, 1'b0, t);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_rom_rd",    {31'd0, if0.rom_rd},    32'd0);
    chk("midrst_pix_valid", {31'd0, if0.pix_valid}, 32'd0);
    chk("midrst_busy",      {31'd0, if0.busy},      32'd0);
    chk("midrst_req_ready", {31'd0, if0.req_ready}, 32'd1);
    exp_q.delete();
    addr_q.delete();
    t_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = n_valid_seen;
    repeat (40) @(negedge clk);
    chk("midrst_no_beat", n_valid_seen, seen);
    chk("midrst_ready_after", {31'd0, if0.req_ready}, 32'd1);

    // Latency sweep
    lat_sweep();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/glyph_row_fetch.md
# glyph_row_fetch

Sequencer between the glyph-select logic and the font ROM of the HDMI overlay font engine. On each request it fetches one 16-word row of a 4-bit-selected glyph from the font ROM, buffers the row locally, and streams it to the pixel serializer over a valid/ready handshake. Each glyph occupies 512 ROM words (base = glyph × 0x200). The block absorbs the ROM read latency and any back-pressure from the overlay path.

## Interface
- ROM_LATENCY, 2, cycles from rom_rd/rom_addr being registered to rom_data valid (legal 1..4)
- DATA_W, 8, font ROM word width
- clk_50MHz  in  1  system clock; all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  row fetch request
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_glyph  in  4  glyph code 0x0..0xF
- req_row  in  5  row within glyph, 0..31
- rom_rd  out  1  ROM read strobe (registered)
- rom_addr  out  13  ROM word address (registered)
- rom_data  in  DATA_W  ROM read data, valid ROM_LATENCY cycles after the strobe
- pix_valid  out  1  output word valid
- pix_ready  in  1  downstream accepts word
- pix_data  out  DATA_W  row word
- pix_last  out  1  marks word 15 of the row
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Address: rom_addr = {req_glyph, req_row, col}, giving glyph×0x200 + row×0x10 + col, with col 0..15. The maximum is 0x1FFF, so the address never wraps.
- Request is accepted when req_valid && req_ready. On acceptance, req_glyph and req_row are latched. Changes to the inputs afterwards have no effect.
- FSM:
  - IDLE: req_ready = 1. Accept → FETCH, col = 0.
  - FETCH: rom_rd = 1 for exactly 16 consecutive cycles, rom_addr incrementing col 0..15. After the 16th strobe → WAIT.
  - WAIT: rom_rd = 0. Stay until the data for col 15 has been captured, then → DRAIN.
  - DRAIN: present buffer[0..15] in order. Advance only on pix_valid && pix_ready. pix_last = 1 with word 15. On the handshake of word 15 → IDLE.
- Capture: a ROM_LATENCY-deep shift register of (strobe, col) tags writes rom_data into buffer[col] on the edge where the tag emerges. The buffer is 16 × DATA_W.
- While pix_valid = 1 and pix_ready = 0, pix_data and pix_last hold stable and pix_valid stays high.
- req_valid is ignored outside IDLE. A request cannot be accepted in the same cycle as the final DRAIN beat.
- Reset values: state IDLE, req_ready 1, rom_rd 0, rom_addr 0, pix_valid 0, pix_data 0, pix_last 0, busy 0, tag pipeline cleared.
- Reset mid-operation: all outputs return to their reset values asynchronously. In-flight ROM returns are discarded and no partial row is emitted. The buffer contents are don't-care.

## Timing
- Request accepted at edge T: rom_rd is high in cycles T+1..T+16 with col 0..15.
- Data for col c is captured at edge T+1+c+ROM_LATENCY. The last capture is at T+16+ROM_LATENCY.
- pix_valid first rises in cycle T+17+ROM_LATENCY.
- With pix_ready held at 1: words appear in cycles T+17+L..T+32+L, pix_last in cycle T+32+L, and req_ready is high again in T+33+L. For L = 2, the row-to-row period is 35 cycles.
- Each cycle of pix_ready = 0 during DRAIN extends the sequence by exactly one cycle.
- busy rises in the cycle after acceptance and falls in the same cycle req_ready rises.

## Test plan
- **Reset:** assert reset_n = 0 mid-FETCH. rom_rd, pix_valid and busy must go to 0 immediately. After release, req_ready = 1 and no pix beat appears.
- **Basic fetch:** glyph 0x3, row 5, ROM model with data = addr[7:0], L = 2, pix_ready = 1.
  - rom_addr must run 0x650..0x65F.
  - pix_data must be 0x50..0x5F in cycles T+19..T+34.
  - pix_last must be high only on 0x5F.
- **Address boundary:** glyph 0xF, row 31. The last address must be 0x1FFF with no wrap. The glyph 0x0, row 0 case must start at 0x000.
- **Back-pressure:** deassert pix_ready for 3 cycles on word 7. Word 7 must stay stable, with no loss or duplication. The 16 words complete 3 cycles later than nominal.
- **Latency sweep:** ROM_LATENCY = 1 and 4. First pix_valid at T+18 and T+21 respectively, with identical data.
- **Busy rejection:** hold req_valid = 1 with new codes throughout a fetch. Only the first request is served. The second is accepted on the cycle req_ready returns high, and its row follows correctly.
